// File: rtl/atm_session_ctrl.sv
// ATM session engine: account table with per-account PIN retry lockout, one card session at a
// time, menu operations with atomic table updates, idle timeout and card eject/retain pulses.
module atm_session_ctrl #(
    parameter int unsigned NUM_ACCOUNTS  = 4,
    parameter int unsigned ACCT_W        = 17,
    parameter int unsigned PIN_W         = 17,
    parameter int unsigned BAL_W         = 19,
    parameter int unsigned MAX_PIN_TRIES = 3,
    parameter int unsigned TIMEOUT_CYC   = 1000
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cfg_we,
    input  logic [$clog2(NUM_ACCOUNTS)-1:0] cfg_idx,
    input  logic [ACCT_W-1:0]               cfg_acct,
    input  logic [PIN_W-1:0]                cfg_pin,
    input  logic [BAL_W-1:0]                cfg_bal,
    input  logic                            card_in,
    input  logic [ACCT_W-1:0]               card_acct,
    input  logic                            pin_valid,
    input  logic [PIN_W-1:0]                pin,
    input  logic                            op_valid,
    input  logic [2:0]                      opcode,
    input  logic [BAL_W-1:0]                amount,
    input  logic [ACCT_W-1:0]               dest_acct,
    input  logic [PIN_W-1:0]                new_pin,
    input  logic                            another_txn,
    output logic                            rsp_valid,
    output logic [2:0]                      rsp_status,
    output logic [BAL_W-1:0]                balance_out,
    output logic                            session_active,
    output logic                            card_eject,
    output logic                            card_retained
);

    localparam int unsigned IDX_W = $clog2(NUM_ACCOUNTS);
    localparam int unsigned TRY_W = 3;
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC);

    localparam logic [2:0] RspOk      = 3'd0;
    localparam logic [2:0] RspBadPin  = 3'd1;
    localparam logic [2:0] RspInsuff  = 3'd2;
    localparam logic [2:0] RspBadAcct = 3'd3;
    localparam logic [2:0] RspBadOp   = 3'd4;
    localparam logic [2:0] RspLocked  = 3'd5;
    localparam logic [2:0] RspTimeout = 3'd6;
    localparam logic [2:0] RspOvfl    = 3'd7;

    localparam logic [2:0] OpBal  = 3'b001;
    localparam logic [2:0] OpWdr  = 3'b010;
    localparam logic [2:0] OpDep  = 3'b011;
    localparam logic [2:0] OpXfer = 3'b100;
    localparam logic [2:0] OpChg  = 3'b101;

    typedef enum logic [1:0] {StIdle, StAuth, StMenu, StEnd} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               card_in_q;
    logic [TRY_W-1:0]   tries_q [NUM_ACCOUNTS];
    logic [TRY_W-1:0]   tries_d [NUM_ACCOUNTS];
    logic [NUM_ACCOUNTS-1:0] lock_q, lock_d;

    // Table storage survives reset; only session bookkeeping is cleared.
    logic [ACCT_W-1:0]  tbl_acct_q [NUM_ACCOUNTS];
    logic [ACCT_W-1:0]  tbl_acct_d [NUM_ACCOUNTS];
    logic [PIN_W-1:0]   tbl_pin_q  [NUM_ACCOUNTS];
    logic [PIN_W-1:0]   tbl_pin_d  [NUM_ACCOUNTS];
    logic [BAL_W-1:0]   tbl_bal_q  [NUM_ACCOUNTS];
    logic [BAL_W-1:0]   tbl_bal_d  [NUM_ACCOUNTS];

    logic               rsp_valid_q, rsp_valid_d;
    logic [2:0]         rsp_status_q, rsp_status_d;
    logic [BAL_W-1:0]   balance_q, balance_d;
    logic               card_eject_q, card_eject_d;
    logic               card_retained_q, card_retained_d;

    logic               card_rise;
    logic               card_hit, dest_hit;
    logic [IDX_W-1:0]   card_idx, dest_idx;
    logic [BAL_W-1:0]   own_bal, dest_bal;
    logic [BAL_W:0]     dep_sum, xfer_sum;

    assign card_rise = card_in & ~card_in_q;

    // Lowest matching index wins if the table ever holds duplicate account numbers.
    always_comb begin
        card_hit = 1'b0;
        card_idx = '0;
        dest_hit = 1'b0;
        dest_idx = '0;
        for (int i = int'(NUM_ACCOUNTS) - 1; i >= 0; i--) begin
            if (tbl_acct_q[i] == card_acct) begin
                card_hit = 1'b1;
                card_idx = IDX_W'(i);
            end
            if (tbl_acct_q[i] == dest_acct) begin
                dest_hit = 1'b1;
                dest_idx = IDX_W'(i);
            end
        end
    end

    assign own_bal  = tbl_bal_q[idx_q];
    assign dest_bal = tbl_bal_q[dest_idx];
    assign dep_sum  = {1'b0, own_bal} + {1'b0, amount};
    assign xfer_sum = {1'b0, dest_bal} + {1'b0, amount};

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        timer_d         = timer_q;
        tries_d         = tries_q;
        lock_d          = lock_q;
        tbl_acct_d      = tbl_acct_q;
        tbl_pin_d       = tbl_pin_q;
        tbl_bal_d       = tbl_bal_q;
        rsp_valid_d     = 1'b0;
        rsp_status_d    = RspOk;
        balance_d       = '0;
        card_eject_d    = 1'b0;
        card_retained_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                timer_d = '0;
                if (card_rise) begin
                    if (!card_hit) begin
                        rsp_valid_d  = 1'b1;
                        rsp_status_d = RspBadAcct;
                        card_eject_d = 1'b1;
                    end else if (lock_q[card_idx]) begin
                        rsp_valid_d     = 1'b1;
                        rsp_status_d    = RspLocked;
                        card_retained_d = 1'b1;
                    end else begin
                        idx_d   = card_idx;
                        state_d = StAuth;
                    end
                end
                // Loop compare rather than direct index so out-of-range cfg_idx is dropped.
                for (int i = 0; i < int'(NUM_ACCOUNTS); i++) begin
                    if (cfg_we && cfg_idx == IDX_W'(i)) begin
                        tbl_acct_d[i] = cfg_acct;
                        tbl_pin_d[i]  = cfg_pin;
                        tbl_bal_d[i]  = cfg_bal;
                    end
                end
            end
            StAuth, StMenu: begin
                if (state_q == StAuth && pin_valid) begin
                    timer_d     = '0;
                    rsp_valid_d = 1'b1;
                    if (pin == tbl_pin_q[idx_q]) begin
                        tries_d[idx_q] = '0;
                        state_d        = StMenu;
                    end else if (tries_q[idx_q] >= TRY_W'(MAX_PIN_TRIES - 1)) begin
                        tries_d[idx_q]  = '0;
                        lock_d[idx_q]   = 1'b1;
                        rsp_status_d    = RspLocked;
                        card_retained_d = 1'b1;
                        state_d         = StIdle;
                    end else begin
                        tries_d[idx_q] = tries_q[idx_q] + 1'b1;
                        rsp_status_d   = RspBadPin;
                    end
                end else if (state_q == StMenu && op_valid) begin
                    timer_d     = '0;
                    rsp_valid_d = 1'b1;
                    balance_d   = own_bal;
                    case (opcode)
                        OpBal: ;
                        OpWdr: begin
                            if (amount > own_bal) begin
                                rsp_status_d = RspInsuff;
                            end else begin
                                tbl_bal_d[idx_q] = own_bal - amount;
                                balance_d        = own_bal - amount;
                            end
                        end
                        OpDep: begin
                            if (dep_sum[BAL_W]) begin
                                rsp_status_d = RspOvfl;
                            end else begin
                                tbl_bal_d[idx_q] = dep_sum[BAL_W-1:0];
                                balance_d        = dep_sum[BAL_W-1:0];
                            end
                        end
                        OpXfer: begin
                            if (!dest_hit || dest_idx == idx_q) begin
                                rsp_status_d = RspBadAcct;
                            end else if (amount > own_bal) begin
                                rsp_status_d = RspInsuff;
                            end else if (xfer_sum[BAL_W]) begin
                                rsp_status_d = RspOvfl;
                            end else begin
                                tbl_bal_d[idx_q]    = own_bal - amount;
                                tbl_bal_d[dest_idx] = xfer_sum[BAL_W-1:0];
                                balance_d           = own_bal - amount;
                            end
                        end
                        OpChg:   tbl_pin_d[idx_q] = new_pin;
                        default: rsp_status_d = RspBadOp;
                    endcase
                    if (!another_txn) begin
                        state_d = StEnd;
                    end
                end else if (card_in && timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = RspTimeout;
                    card_eject_d = 1'b1;
                    state_d      = StIdle;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
                // A pulled card aborts silently; a strobe taken this cycle still completes.
                if (!card_in) begin
                    state_d = StIdle;
                end
            end
            StEnd: begin
                card_eject_d = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            idx_q           <= '0;
            timer_q         <= '0;
            card_in_q       <= 1'b0;
            tries_q         <= '{default: '0};
            lock_q          <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_status_q    <= RspOk;
            balance_q       <= '0;
            card_eject_q    <= 1'b0;
            card_retained_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            timer_q         <= timer_d;
            card_in_q       <= card_in;
            tries_q         <= tries_d;
            lock_q          <= lock_d;
            tbl_acct_q      <= tbl_acct_d;
            tbl_pin_q       <= tbl_pin_d;
            tbl_bal_q       <= tbl_bal_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_status_q    <= rsp_status_d;
            balance_q       <= balance_d;
            card_eject_q    <= card_eject_d;
            card_retained_q <= card_retained_d;
        end
    end

    assign rsp_valid      = rsp_valid_q;
    assign rsp_status     = rsp_status_q;
    assign balance_out    = balance_q;
    assign card_eject     = card_eject_q;
    assign card_retained  = card_retained_q;
    assign session_active = (state_q == StAuth) || (state_q == StMenu);

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Bench for atm_session_ctrl: directed scenarios with literal expectations, then randomized
// sessions, all checked every cycle against a behavioural account/session model.
module tb_atm_session_ctrl;
    localparam int N    = 4;
    localparam int AW   = 17;
    localparam int PW   = 17;
    localparam int BW   = 19;
    localparam int MAXT = 3;
    localparam int TO   = 40;
    localparam int BMAX = (1 << BW) - 1;
    localparam int PI = 0, PA = 1, PM = 2, PE = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_idx = '0;
    logic [AW-1:0] cfg_acct = '0;
    logic [PW-1:0] cfg_pin = '0;
    logic [BW-1:0] cfg_bal = '0;
    logic          card_in = 1'b0;
    logic [AW-1:0] card_acct = '0;
    logic          pin_valid = 1'b0;
    logic [PW-1:0] pin = '0;
    logic          op_valid = 1'b0;
    logic [2:0]    opcode = '0;
    logic [BW-1:0] amount = '0;
    logic [AW-1:0] dest_acct = '0;
    logic [PW-1:0] new_pin = '0;
    logic          another_txn = 1'b1;
    logic          rsp_valid;
    logic [2:0]    rsp_status;
    logic [BW-1:0] balance_out;
    logic          session_active;
    logic          card_eject;
    logic          card_retained;

    int vectors = 0;
    int miscompares = 0;

    atm_session_ctrl #(
        .NUM_ACCOUNTS(N), .ACCT_W(AW), .PIN_W(PW), .BAL_W(BW),
        .MAX_PIN_TRIES(MAXT), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_acct(cfg_acct), .cfg_pin(cfg_pin),
        .cfg_bal(cfg_bal), .card_in(card_in), .card_acct(card_acct),
        .pin_valid(pin_valid), .pin(pin), .op_valid(op_valid), .opcode(opcode),
        .amount(amount), .dest_acct(dest_acct), .new_pin(new_pin), .another_txn(another_txn),
        .rsp_valid(rsp_valid), .rsp_status(rsp_status), .balance_out(balance_out),
        .session_active(session_active), .card_eject(card_eject),
        .card_retained(card_retained)
    );

    always #5 clk = ~clk;

    // Behavioural model: account records, per-account tries/lock, and the session phase.
    logic [AW-1:0] m_acct [N];
    logic [PW-1:0] m_pin  [N];
    logic [BW-1:0] m_bal  [N];
    int            m_tries [N];
    bit            m_lock  [N];
    int            m_ph = PI, m_sess = 0, m_idle = 0;
    bit            m_cprev = 0, m_started = 0;
    bit            e_rv = 0, e_ej = 0, e_ret = 0, e_sa = 0;
    logic [2:0]    e_st = '0;
    logic [BW-1:0] e_bal = '0;

    function automatic int find(input logic [AW-1:0] a);
        for (int i = 0; i < N; i++) if (m_acct[i] == a) return i;
        return -1;
    endfunction

    always @(posedge clk) begin : model
        int k;
        int s;
        e_rv = 0; e_st = 0; e_bal = 0; e_ej = 0; e_ret = 0;
        if (reset) begin
            m_ph = PI; m_cprev = 0; m_idle = 0; m_started = 1;
            for (int i = 0; i < N; i++) begin m_tries[i] = 0; m_lock[i] = 0; end
        end else begin
            if (m_ph == PI) begin
                if (card_in && !m_cprev) begin
                    k = find(card_acct);
                    if (k < 0) begin e_rv = 1; e_st = 3; e_ej = 1; end
                    else if (m_lock[k]) begin e_rv = 1; e_st = 5; e_ret = 1; end
                    else begin m_sess = k; m_ph = PA; m_idle = 0; end
                end
                if (cfg_we) begin
                    m_acct[cfg_idx] = cfg_acct; m_pin[cfg_idx] = cfg_pin; m_bal[cfg_idx] = cfg_bal;
                end
            end else if (m_ph == PA || m_ph == PM) begin
                s = m_sess;
                if (m_ph == PA && pin_valid) begin
                    m_idle = 0; e_rv = 1;
                    if (pin == m_pin[s]) begin m_tries[s] = 0; m_ph = PM; end
                    else begin
                        m_tries[s]++;
                        if (m_tries[s] >= MAXT) begin
                            m_lock[s] = 1; m_tries[s] = 0; e_st = 5; e_ret = 1; m_ph = PI;
                        end else e_st = 1;
                    end
                end else if (m_ph == PM && op_valid) begin
                    m_idle = 0; e_rv = 1;
                    case (opcode)
                        3'd1: ;
                        3'd2: if (amount > m_bal[s]) e_st = 2; else m_bal[s] = m_bal[s] - amount;
                        3'd3: if (int'(m_bal[s]) + int'(amount) > BMAX) e_st = 7;
                              else m_bal[s] = m_bal[s] + amount;
                        3'd4: begin
                            k = find(dest_acct);
                            if (k < 0 || k == s) e_st = 3;
                            else if (amount > m_bal[s]) e_st = 2;
                            else if (int'(m_bal[k]) + int'(amount) > BMAX) e_st = 7;
                            else begin m_bal[s] = m_bal[s] - amount; m_bal[k] = m_bal[k] + amount; end
                        end
                        3'd5: m_pin[s] = new_pin;
                        default: e_st = 4;
                    endcase
                    e_bal = m_bal[s];
                    if (!another_txn) m_ph = PE;
                end else if (card_in && m_idle + 1 == TO) begin
                    e_rv = 1; e_st = 6; e_ej = 1; m_ph = PI;
                end else m_idle++;
                if (!card_in) m_ph = PI;
            end else begin
                e_ej = 1; m_ph = PI;
            end
            m_cprev = card_in;
        end
        e_sa = (m_ph == PA || m_ph == PM);
    end

    always @(negedge clk) begin
        if (m_started) begin
            vectors++;
            if (rsp_valid !== e_rv || rsp_status !== e_st || balance_out !== e_bal ||
                card_eject !== e_ej || card_retained !== e_ret || session_active !== e_sa) begin
                miscompares++;
                $display("FAIL cycle_outputs t=%0t: got rv=%b st=%0d bal=%0d ej=%b ret=%b act=%b, expected rv=%b st=%0d bal=%0d ej=%b ret=%b act=%b",
                         $time, rsp_valid, rsp_status, balance_out, card_eject, card_retained,
                         session_active, e_rv, e_st, e_bal, e_ej, e_ret, e_sa);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int i, input logic [AW-1:0] a, input logic [PW-1:0] p,
                             input logic [BW-1:0] b);
        cfg_we = 1; cfg_idx = 2'(i); cfg_acct = a; cfg_pin = p; cfg_bal = b;
        step();
        cfg_we = 0;
    endtask

    task automatic insert(input logic [AW-1:0] a);
        card_acct = a; card_in = 1;
        step();
    endtask

    task automatic remove();
        card_in = 0;
        step();
    endtask

    task automatic enter_pin(input logic [PW-1:0] p);
        pin = p; pin_valid = 1;
        step();
        pin_valid = 0;
    endtask

    task automatic do_op(input logic [2:0] oc, input int amt, input logic [AW-1:0] dst,
                         input logic [PW-1:0] np, input bit another);
        opcode = oc; amount = BW'(amt); dest_acct = dst; new_pin = np; another_txn = another;
        op_valid = 1;
        step();
        op_valid = 0;
    endtask

    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog: got no finish, expected finish within 200000 cycles");
        $fatal(1, "watchdog expired");
    end

    logic [AW-1:0] pool [6];
    int r;

    initial begin
        pool = '{17'h0C5AA, 17'h0705C, 17'h03219, 17'h08629, 17'h01111, 17'h00ABC};
        repeat (3) step();
        reset = 0;
        check("reset_rsp_valid", 32'(rsp_valid), 0);
        check("reset_status", 32'(rsp_status), 0);
        check("reset_balance", 32'(balance_out), 0);
        check("reset_active", 32'(session_active), 0);
        check("reset_eject", 32'(card_eject | card_retained), 0);

        cfg_write(0, 17'h0C5AA, 17'h01F5E, 19'd5000);
        cfg_write(1, 17'h0705C, 17'h004BF, 19'd8000);
        cfg_write(2, 17'h03219, 17'h004D2, 19'd7500);
        cfg_write(3, 17'h08629, 17'h00D05, 19'd3000);

        // Withdraw then balance enquiry, normal end.
        insert(17'h0C5AA);
        check("t1_active", 32'(session_active), 1);
        enter_pin(17'h01F5E);
        check("t1_pin_ok", {29'd0, rsp_status} | {31'd0, ~rsp_valid}, 0);
        do_op(3'd2, 500, '0, '0, 1);
        check("t1_wdr_status", 32'(rsp_status), 0);
        check("t1_wdr_bal", 32'(balance_out), 4500);
        do_op(3'd1, 0, '0, '0, 0);
        check("t1_bal_bal", 32'(balance_out), 4500);
        step();
        check("t1_eject", 32'(card_eject), 1);
        remove();

        // PIN lockout and reinsert of the locked card.
        insert(17'h0C5AA);
        enter_pin(17'h00001);
        check("t2_bad1", 32'(rsp_status), 1);
        enter_pin(17'h00002);
        check("t2_bad2", 32'(rsp_status), 1);
        enter_pin(17'h00003);
        check("t2_locked", 32'(rsp_status), 5);
        check("t2_retained", 32'(card_retained), 1);
        check("t2_inactive", 32'(session_active), 0);
        remove();
        insert(17'h0C5AA);
        check("t2_relock", 32'(rsp_status), 5);
        check("t2_reretain", 32'(card_retained), 1);
        remove();

        // Transfer, self-transfer rejection, destination balance.
        insert(17'h0705C);
        enter_pin(17'h004BF);
        do_op(3'd4, 200, 17'h03219, '0, 1);
        check("t3_xfer_status", 32'(rsp_status), 0);
        check("t3_xfer_bal", 32'(balance_out), 7800);
        do_op(3'd4, 50, 17'h0705C, '0, 1);
        check("t3_self_status", 32'(rsp_status), 3);
        check("t3_self_bal", 32'(balance_out), 7800);
        remove();
        insert(17'h03219);
        enter_pin(17'h004D2);
        do_op(3'd1, 0, '0, '0, 1);
        check("t3_dest_bal", 32'(balance_out), 7700);
        remove();
        check("t3_abort", 32'(session_active), 0);

        // Overflow, insufficient, bad opcode, PIN change with end.
        insert(17'h08629);
        enter_pin(17'h00D05);
        do_op(3'd3, BMAX, '0, '0, 1);
        check("t4_ovfl", 32'(rsp_status), 7);
        check("t4_ovfl_bal", 32'(balance_out), 3000);
        do_op(3'd2, 3001, '0, '0, 1);
        check("t4_insuff", 32'(rsp_status), 2);
        do_op(3'd7, 0, '0, '0, 1);
        check("t4_badop", 32'(rsp_status), 4);
        do_op(3'd5, 0, '0, 17'h01234, 0);
        check("t5_chg", 32'(rsp_status), 0);
        step();
        check("t5_eject", 32'(card_eject), 1);
        remove();
        insert(17'h08629);
        enter_pin(17'h00D05);
        check("t5_oldpin", 32'(rsp_status), 1);

        // Idle timeout.
        repeat (TO - 1) step();
        check("t6_no_early_timeout", 32'(rsp_valid), 0);
        step();
        check("t6_timeout", 32'(rsp_status), 6);
        check("t6_timeout_eject", 32'(card_eject), 1);
        check("t6_timeout_inactive", 32'(session_active), 0);
        remove();

        // Reset while an op is presented in MENU.
        insert(17'h0705C);
        enter_pin(17'h004BF);
        opcode = 3'd2; amount = 19'd100; another_txn = 1; op_valid = 1; reset = 1;
        step();
        check("t6_rst_valid", 32'(rsp_valid), 0);
        check("t6_rst_bal", 32'(balance_out), 0);
        check("t6_rst_active", 32'(session_active), 0);
        reset = 0; op_valid = 0; card_in = 0;
        step();
        insert(17'h0705C);
        enter_pin(17'h004BF);
        do_op(3'd1, 0, '0, '0, 1);
        check("t6_rst_no_write", 32'(balance_out), 7800);
        remove();
        insert(17'h0C5AA);
        enter_pin(17'h01F5E);
        check("t6_lock_cleared", {29'd0, rsp_status} | {31'd0, ~rsp_valid}, 0);
        remove();

        // Table write coincident with card insertion matches the old contents.
        cfg_we = 1; cfg_idx = 2'd3; cfg_acct = 17'h01111; cfg_pin = 17'h02222; cfg_bal = 19'd100;
        card_acct = 17'h01111; card_in = 1;
        step();
        cfg_we = 0;
        check("cfg_race_badacct", 32'(rsp_status), 3);
        check("cfg_race_eject", 32'(card_eject), 1);
        remove();
        insert(17'h01111);
        enter_pin(17'h02222);
        do_op(3'd1, 0, '0, '0, 1);
        check("cfg_new_entry_bal", 32'(balance_out), 100);
        remove();

        // Randomized sessions.
        for (int s = 0; s < 150; s++) begin
            if ($urandom_range(0, 3) == 0)
                cfg_write($urandom_range(0, N - 1), pool[$urandom_range(0, 5)],
                          PW'($urandom_range(0, 3)),
                          ($urandom_range(0, 3) == 0) ? BW'($urandom) : BW'($urandom_range(0, 9000)));
            card_acct = pool[$urandom_range(0, 5)];
            card_in = 1;
            if ($urandom_range(0, 5) == 0) begin
                cfg_we = 1; cfg_idx = 2'($urandom_range(0, N - 1));
                cfg_acct = pool[$urandom_range(0, 5)]; cfg_pin = PW'($urandom_range(0, 3));
                cfg_bal = BW'($urandom_range(0, 9000));
            end
            step();
            cfg_we = 0;
            for (int k = 0; k < 12 && (m_ph == PA || m_ph == PM); k++) begin
                r = $urandom_range(0, 39);
                if (r == 1) begin
                    repeat ($urandom_range(0, TO + 3)) step();
                end else if (r == 2) begin
                    reset = 1;
                    step();
                    reset = 0;
                end else begin
                    if (r == 0) card_in = 0;
                    pin = ($urandom_range(0, 2) != 0) ? m_pin[m_sess] : PW'($urandom_range(0, 3));
                    pin_valid = (m_ph == PA) ? 1'b1 : 1'($urandom_range(0, 1));
                    op_valid = (m_ph == PM) ? 1'b1 : 1'($urandom_range(0, 1));
                    opcode = 3'($urandom_range(0, 7));
                    amount = ($urandom_range(0, 5) == 0) ? BW'($urandom) : BW'($urandom_range(0, 6000));
                    dest_acct = pool[$urandom_range(0, 5)];
                    new_pin = PW'($urandom_range(0, 3));
                    another_txn = ($urandom_range(0, 5) != 0);
                    step();
                    pin_valid = 0; op_valid = 0;
                end
            end
            card_in = 0;
            step();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
